// File: rtl/data_sample_voter.sv
// data_sample_voter: takes NUM_SAMPLES oversampled copies of RX_IN around
// the centre of each bit and outputs the majority value with a noise flag.
module data_sample_voter #(
  parameter int unsigned NUM_SAMPLES = 3,
  parameter int unsigned PRESCALE_W  = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_samp_en,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  RX_IN,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  noise_flag,
  output logic                  cfg_err
);

  localparam int unsigned AW    = PRESCALE_W + 1;
  localparam int unsigned HALF  = (NUM_SAMPLES - 1) / 2;
  localparam int unsigned IDX_W = $clog2(NUM_SAMPLES + 1);
  localparam int unsigned MAJ   = (NUM_SAMPLES + 1) / 2;

  logic                   rx_s;
  logic [AW-1:0]          centre;
  logic [AW-1:0]          win_first;
  logic [AW-1:0]          win_last;
  logic [AW-1:0]          edge_x;
  logic                   in_win;
  logic                   at_last;
  logic                   cfg_bad;
  logic                   window_full;
  logic [NUM_SAMPLES-1:0] samp_q;
  logic [NUM_SAMPLES-1:0] samp_merged;
  logic [IDX_W-1:0]       idx_q;
  logic [IDX_W-1:0]       ones;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign rx_s = RX_IN;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Line synchroniser; flops idle high so reset looks like a quiet line.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync_q <= '1;
        end else begin
          sync_q <= SYNC_STAGES'({sync_q, RX_IN});
        end
      end

      assign rx_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Sampling window centred on the bit, computed one bit wider so that an
  // undersized Prescale wraps instead of aliasing into a valid window.
  assign centre      = AW'(Prescale >> 1) - AW'(1);
  assign win_first   = centre - AW'(HALF);
  assign win_last    = centre + AW'(HALF);
  assign edge_x      = AW'(edge_cnt);
  assign in_win      = (edge_x >= win_first) && (edge_x <= win_last);
  assign at_last     = (edge_x == win_last);
  assign cfg_bad     = AW'(Prescale) < AW'(NUM_SAMPLES + 1);
  assign window_full = at_last && (idx_q == IDX_W'(NUM_SAMPLES - 1));

  // Sample vector including the value being captured now, and its popcount.
  always_comb begin
    samp_merged = samp_q;
    for (int i = 0; i < NUM_SAMPLES; i++) begin
      if (idx_q == IDX_W'(i)) samp_merged[i] = rx_s;
    end
    ones = '0;
    for (int i = 0; i < NUM_SAMPLES; i++) begin
      ones = ones + IDX_W'(samp_merged[i]);
    end
  end

  // Capture, bit restart and vote; the vote registers on the last capture edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_err      <= 1'b0;
      sampled_bit  <= 1'b0;
      noise_flag   <= 1'b0;
      sample_valid <= 1'b0;
      idx_q        <= '0;
      samp_q       <= '0;
    end else begin
      cfg_err      <= cfg_bad;
      sample_valid <= 1'b0;
      if (!data_samp_en) begin
        sampled_bit <= 1'b0;
        noise_flag  <= 1'b0;
        idx_q       <= '0;
        samp_q      <= '0;
      end else if (edge_cnt == '0) begin
        idx_q  <= '0;
        samp_q <= '0;
      end else if (!cfg_err && in_win) begin
        samp_q <= samp_merged;
        if (idx_q < IDX_W'(NUM_SAMPLES)) idx_q <= idx_q + IDX_W'(1);
        if (window_full) begin
          sampled_bit  <= (ones >= IDX_W'(MAJ));
          noise_flag   <= (ones != '0) && (ones != IDX_W'(NUM_SAMPLES));
          sample_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sample_voter.sv
// tb_data_sample_voter: three voter configurations driven by directed and
// random bit periods, compared every cycle against a counting model.
module tb_data_sample_voter;

  localparam int PW   = 6;
  localparam int MASK = (1 << (PW + 1)) - 1;
  localparam int NS [3] = '{3, 5, 3};
  localparam int SS [3] = '{0, 0, 2};

  logic          clk = 1'b0;
  logic          rst;
  logic          en  [3];
  logic [PW-1:0] ec  [3];
  logic [PW-1:0] pre [3];
  logic          rx  [3];
  logic          sb  [3];
  logic          sv  [3];
  logic          nf  [3];
  logic          ce  [3];

  bit m_sb [3];
  bit m_sv [3];
  bit m_nf [3];
  bit m_ce [3];
  int m_cnt  [3];
  int m_ones [3];
  bit hist [3][3];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_sample_voter #(.NUM_SAMPLES(3), .PRESCALE_W(PW), .SYNC_STAGES(0)) u_n3 (
    .clk(clk), .reset(rst), .data_samp_en(en[0]), .edge_cnt(ec[0]),
    .Prescale(pre[0]), .RX_IN(rx[0]), .sampled_bit(sb[0]),
    .sample_valid(sv[0]), .noise_flag(nf[0]), .cfg_err(ce[0]));

  data_sample_voter #(.NUM_SAMPLES(5), .PRESCALE_W(PW), .SYNC_STAGES(0)) u_n5 (
    .clk(clk), .reset(rst), .data_samp_en(en[1]), .edge_cnt(ec[1]),
    .Prescale(pre[1]), .RX_IN(rx[1]), .sampled_bit(sb[1]),
    .sample_valid(sv[1]), .noise_flag(nf[1]), .cfg_err(ce[1]));

  data_sample_voter #(.NUM_SAMPLES(3), .PRESCALE_W(PW), .SYNC_STAGES(2)) u_sync (
    .clk(clk), .reset(rst), .data_samp_en(en[2]), .edge_cnt(ec[2]),
    .Prescale(pre[2]), .RX_IN(rx[2]), .sampled_bit(sb[2]),
    .sample_valid(sv[2]), .noise_flag(nf[2]), .cfg_err(ce[2]));

  function automatic void model_reset(int d);
    m_sb[d] = 1'b0; m_sv[d] = 1'b0; m_nf[d] = 1'b0; m_ce[d] = 1'b0;
    m_cnt[d] = 0; m_ones[d] = 0;
    for (int k = 0; k < 3; k++) hist[d][k] = 1'b1;
  endfunction

  // One clock of behaviour for configuration d, from the current inputs.
  function automatic void model_step(int d);
    int n = NS[d];
    int s = SS[d];
    int p, e, line, centre, lo, hi, tot;
    if (!rst) begin
      model_reset(d);
      return;
    end
    p      = int'(pre[d]);
    e      = int'(ec[d]);
    line   = (s == 0) ? int'(rx[d]) : int'(hist[d][s-1]);
    centre = (p / 2 - 1) & MASK;
    lo     = (centre - (n - 1) / 2) & MASK;
    hi     = (centre + (n - 1) / 2) & MASK;
    m_sv[d] = 1'b0;
    if (!en[d]) begin
      m_sb[d] = 1'b0; m_nf[d] = 1'b0; m_cnt[d] = 0; m_ones[d] = 0;
    end else if (e == 0) begin
      m_cnt[d] = 0; m_ones[d] = 0;
    end else if (!m_ce[d] && e >= lo && e <= hi && m_cnt[d] < n) begin
      if (e == hi && m_cnt[d] == n - 1) begin
        tot = m_ones[d] + line;
        m_sb[d] = (2 * tot > n);
        m_nf[d] = (tot != 0) && (tot != n);
        m_sv[d] = 1'b1;
      end
      m_ones[d] = m_ones[d] + line;
      m_cnt[d]  = m_cnt[d] + 1;
    end
    m_ce[d] = (p < n + 1);
    hist[d][2] = hist[d][1];
    hist[d][1] = hist[d][0];
    hist[d][0] = rx[d];
  endfunction

  task automatic cyc();
    for (int d = 0; d < 3; d++) model_step(d);
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    for (int d = 0; d < 3; d++) begin
      en[d] = 1'b0; ec[d] = '0; rx[d] = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_idle();
    for (int d = 0; d < 3; d++) pre[d] = PW'(16);
    cyc();
    cyc();
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if ({sv[d], sb[d], nf[d], ce[d]} !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset dut%0d sv/sb/nf/ce=%b required 0000", d, {sv[d], sb[d], nf[d], ce[d]});
      end
    end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_unanimous();
    pre[0] = PW'(8);
    en[0]  = 1'b1;
    for (int e = 0; e < 8; e++) begin
      ec[0] = PW'(e);
      rx[0] = (e >= 2 && e <= 4) ? 1'b1 : 1'($urandom_range(0, 1));
      cyc();
      vectors++;
      if ({sv[0], sb[0], nf[0], ce[0]} !== {m_sv[0], m_sb[0], m_nf[0], m_ce[0]}) begin
        miscompares++;
        $display("FAIL unanimous ec=%0d sv/sb/nf/ce=%b required %b", e,
                 {sv[0], sb[0], nf[0], ce[0]}, {m_sv[0], m_sb[0], m_nf[0], m_ce[0]});
      end
      if (e == 4 || e == 5) begin
        vectors++;
        if ({sv[0], sb[0], nf[0]} !== ((e == 4) ? 3'b110 : 3'b010)) begin
          miscompares++;
          $display("FAIL unanimous_vote ec=%0d sv/sb/nf=%b required %b", e,
                   {sv[0], sb[0], nf[0]}, (e == 4) ? 3'b110 : 3'b010);
        end
      end
    end
    en[0] = 1'b0;
    cyc();
  endtask

  task automatic test_noisy3();
    logic [2:0] pat;
    pat    = 3'b010;
    pre[0] = PW'(16);
    en[0]  = 1'b1;
    for (int e = 0; e < 16; e++) begin
      ec[0] = PW'(e);
      rx[0] = (e >= 6 && e <= 8) ? pat[e-6] : 1'($urandom_range(0, 1));
      cyc();
      vectors++;
      if ({sv[0], sb[0], nf[0], ce[0]} !== {m_sv[0], m_sb[0], m_nf[0], m_ce[0]}) begin
        miscompares++;
        $display("FAIL noisy3 ec=%0d sv/sb/nf/ce=%b required %b", e,
                 {sv[0], sb[0], nf[0], ce[0]}, {m_sv[0], m_sb[0], m_nf[0], m_ce[0]});
      end
      if (e == 8) begin
        vectors++;
        if ({sv[0], sb[0], nf[0]} !== 3'b101) begin
          miscompares++;
          $display("FAIL noisy3_vote sv/sb/nf=%b required 101", {sv[0], sb[0], nf[0]});
        end
      end
    end
    en[0] = 1'b0;
    cyc();
  endtask

  task automatic test_noisy5();
    logic [4:0] pat;
    pat    = 5'b10101;
    pre[1] = PW'(16);
    en[1]  = 1'b1;
    for (int e = 0; e < 16; e++) begin
      ec[1] = PW'(e);
      rx[1] = (e >= 5 && e <= 9) ? pat[e-5] : 1'($urandom_range(0, 1));
      cyc();
      vectors++;
      if ({sv[1], sb[1], nf[1], ce[1]} !== {m_sv[1], m_sb[1], m_nf[1], m_ce[1]}) begin
        miscompares++;
        $display("FAIL noisy5 ec=%0d sv/sb/nf/ce=%b required %b", e,
                 {sv[1], sb[1], nf[1], ce[1]}, {m_sv[1], m_sb[1], m_nf[1], m_ce[1]});
      end
      if (e == 8 || e == 9) begin
        vectors++;
        if ({sv[1], nf[1]} !== ((e == 9) ? 2'b11 : 2'b00) || (e == 9 && sb[1] !== 1'b1)) begin
          miscompares++;
          $display("FAIL noisy5_vote ec=%0d sv/sb/nf=%b required %s", e,
                   {sv[1], sb[1], nf[1]}, (e == 9) ? "111" : "sv=0 nf=0");
        end
      end
    end
    en[1] = 1'b0;
    cyc();
  endtask

  task automatic test_cfg_err();
    int pulses_bad  = 0;
    int pulses_good = 0;
    pre[1] = PW'(4);
    en[1]  = 1'b1;
    for (int c = 0; c < 12; c++) begin
      ec[1] = PW'(c % 4);
      rx[1] = 1'($urandom_range(0, 1));
      cyc();
      if (sv[1] === 1'b1) pulses_bad++;
      vectors++;
      if ({sv[1], sb[1], nf[1], ce[1]} !== {m_sv[1], m_sb[1], m_nf[1], m_ce[1]} || ce[1] !== 1'b1) begin
        miscompares++;
        $display("FAIL cfg_err_small c=%0d sv/sb/nf/ce=%b required %b with ce=1", c,
                 {sv[1], sb[1], nf[1], ce[1]}, {m_sv[1], m_sb[1], m_nf[1], m_ce[1]});
      end
    end
    pre[1] = PW'(8);
    for (int e = 0; e < 8; e++) begin
      ec[1] = PW'(e);
      rx[1] = 1'($urandom_range(0, 1));
      cyc();
      if (sv[1] === 1'b1) pulses_good++;
      vectors++;
      if ({sv[1], sb[1], nf[1], ce[1]} !== {m_sv[1], m_sb[1], m_nf[1], m_ce[1]}) begin
        miscompares++;
        $display("FAIL cfg_err_ok ec=%0d sv/sb/nf/ce=%b required %b", e,
                 {sv[1], sb[1], nf[1], ce[1]}, {m_sv[1], m_sb[1], m_nf[1], m_ce[1]});
      end
    end
    vectors++;
    if (pulses_bad != 0 || pulses_good != 1 || ce[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg_err_votes pulses small=%0d ok=%0d ce=%b required 0 1 0",
               pulses_bad, pulses_good, ce[1]);
    end
    en[1] = 1'b0;
    cyc();
  endtask

  task automatic test_drop_en();
    pre[0] = PW'(8);
    en[0]  = 1'b1;
    for (int c = 0; c < 13; c++) begin
      ec[0] = PW'(c % 8);
      rx[0] = 1'b1;
      en[0] = (c != 12);
      cyc();
      vectors++;
      if ({sv[0], sb[0], nf[0], ce[0]} !== {m_sv[0], m_sb[0], m_nf[0], m_ce[0]}) begin
        miscompares++;
        $display("FAIL drop_en c=%0d sv/sb/nf/ce=%b required %b", c,
                 {sv[0], sb[0], nf[0], ce[0]}, {m_sv[0], m_sb[0], m_nf[0], m_ce[0]});
      end
      if (c == 11 || c == 12) begin
        vectors++;
        if ({sv[0], sb[0]} !== ((c == 11) ? 2'b01 : 2'b00)) begin
          miscompares++;
          $display("FAIL drop_en_vote c=%0d sv/sb=%b required %b", c,
                   {sv[0], sb[0]}, (c == 11) ? 2'b01 : 2'b00);
        end
      end
    end
    en[0] = 1'b0;
    cyc();
  endtask

  task automatic test_sync_reset();
    pre[2] = PW'(8);
    en[2]  = 1'b1;
    for (int e = 0; e < 8; e++) begin
      ec[2] = PW'(e);
      rx[2] = (e == 0);
      cyc();
      vectors++;
      if ({sv[2], sb[2], nf[2], ce[2]} !== {m_sv[2], m_sb[2], m_nf[2], m_ce[2]}) begin
        miscompares++;
        $display("FAIL sync ec=%0d sv/sb/nf/ce=%b required %b", e,
                 {sv[2], sb[2], nf[2], ce[2]}, {m_sv[2], m_sb[2], m_nf[2], m_ce[2]});
      end
      if (e == 4) begin
        vectors++;
        if ({sv[2], sb[2], nf[2]} !== 3'b101) begin
          miscompares++;
          $display("FAIL sync_first_sample sv/sb/nf=%b required 101", {sv[2], sb[2], nf[2]});
        end
      end
    end
    for (int e = 0; e < 8; e++) begin
      ec[2] = PW'(e);
      rx[2] = 1'b1;
      if (e == 3) begin
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) model_reset(d);
        vectors++;
        if ({sv[2], sb[2], nf[2], ce[2]} !== 4'b0000) begin
          miscompares++;
          $display("FAIL reset_mid sv/sb/nf/ce=%b required 0000", {sv[2], sb[2], nf[2], ce[2]});
        end
      end
      cyc();
      if (e == 3) rst = 1'b1;
      vectors++;
      if ({sv[2], sb[2], nf[2], ce[2]} !== {m_sv[2], m_sb[2], m_nf[2], m_ce[2]}
          || (e >= 3 && sv[2] !== 1'b0)) begin
        miscompares++;
        $display("FAIL reset_window ec=%0d sv/sb/nf/ce=%b required %b, no vote", e,
                 {sv[2], sb[2], nf[2], ce[2]}, {m_sv[2], m_sb[2], m_nf[2], m_ce[2]});
      end
    end
    en[2] = 1'b0;
    cyc();
  endtask

  task automatic test_random();
    int p, skip, drop;
    for (int d = 0; d < 3; d++) begin
      for (int b = 0; b < 14; b++) begin
        p      = 2 * $urandom_range(1, 10);
        pre[d] = PW'(p);
        skip   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, p - 1) : -1;
        drop   = ($urandom_range(0, 6) == 0) ? $urandom_range(0, p - 1) : -1;
        for (int e = 0; e < p; e++) begin
          if (e == skip) continue;
          ec[d] = PW'(e);
          en[d] = (e != drop);
          rx[d] = 1'($urandom_range(0, 1));
          cyc();
          vectors++;
          if ({sv[d], sb[d], nf[d], ce[d]} !== {m_sv[d], m_sb[d], m_nf[d], m_ce[d]}) begin
            miscompares++;
            $display("FAIL random dut%0d pre=%0d ec=%0d sv/sb/nf/ce=%b required %b", d, p, e,
                     {sv[d], sb[d], nf[d], ce[d]}, {m_sv[d], m_sb[d], m_nf[d], m_ce[d]});
          end
        end
      end
      en[d] = 1'b0;
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_unanimous();
    test_noisy3();
    test_noisy5();
    test_cfg_err();
    test_drop_en();
    test_sync_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_sample_voter.md
DATA_SAMPLE_VOTER -- requirements
Module: data_sample_voter

Interface
REQ-001 Parameter NUM_SAMPLES, default 3, odd sample count per bit; legal values 3, 5, 7.
REQ-002 Parameter PRESCALE_W, default 6, width of Prescale and edge_cnt.
REQ-003 Parameter SYNC_STAGES, default 2, RX_IN synchroniser depth; legal values 0 to 3, where 0 means direct use.
REQ-004 clk  input  1  single clock; all flops on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 data_samp_en  input  1  sampling enable from the RX FSM.
REQ-007 edge_cnt  input  PRESCALE_W  oversampling edge counter within the current bit (0..Prescale-1).
REQ-008 Prescale  input  PRESCALE_W  oversampling ratio; even values only.
REQ-009 RX_IN  input  1  serial line.
REQ-010 sampled_bit  output  1  majority-voted bit value.
REQ-011 sample_valid  output  1  one-cycle strobe marking a new sampled_bit.
REQ-012 noise_flag  output  1  the last vote was not unanimous.
REQ-013 cfg_err  output  1  Prescale is too small for NUM_SAMPLES.

Function
REQ-014 rx_s SHALL be RX_IN delayed through SYNC_STAGES flops, each reset to 1; rx_s is the only line value sampled.
REQ-015 Window arithmetic SHALL be unsigned and PRESCALE_W+1 bits wide:
  - centre = (Prescale>>1)-1
  - first = centre-(NUM_SAMPLES-1)/2
  - last = centre+(NUM_SAMPLES-1)/2
REQ-016 cfg_err SHALL be registered and equal 1 when Prescale < NUM_SAMPLES+1, independent of data_samp_en.
REQ-017 While cfg_err=1 the block SHALL capture no samples and emit no sample_valid.
REQ-018 The block SHALL keep a NUM_SAMPLES-bit sample register and a sample index idx.
REQ-019 Capture rule, when data_samp_en=1 and cfg_err=0:
  - on each cycle with first <= edge_cnt <= last, store rx_s into sample slot idx;
  - then increment idx.
REQ-020 edge_cnt==0 with data_samp_en=1 SHALL clear idx and the sample register (bit restart), taking precedence over capture.
REQ-021 Vote rule: in the cycle after a capture at edge_cnt==last with idx==NUM_SAMPLES-1, the block SHALL:
  - load sampled_bit = 1 when popcount(samples) >= (NUM_SAMPLES+1)/2, else 0;
  - set noise_flag = 1 when popcount is neither 0 nor NUM_SAMPLES;
  - pulse sample_valid for exactly one cycle.
  Latency: vote appears one clock after the last capture edge.
REQ-022 An incomplete window SHALL produce no vote. Example: edge_cnt skips a sample point so idx != NUM_SAMPLES-1 at last.
REQ-023 sampled_bit and noise_flag SHALL hold between votes while data_samp_en=1.
REQ-024 data_samp_en=0 SHALL, on the next clock, clear sampled_bit, noise_flag, sample_valid, idx and the sample register.
REQ-025 Deassertion of data_samp_en in the cycle of the last capture SHALL suppress that vote.
REQ-026 A Prescale change mid-bit SHALL take effect immediately on window comparisons; no protection is provided.

Reset
REQ-027 While reset=0, the block SHALL hold:
  - sampled_bit=0, sample_valid=0, noise_flag=0, cfg_err=0;
  - idx=0, sample register=0;
  - synchroniser flops=1.
REQ-028 Reset asserted mid-window SHALL discard partial samples; no sample_valid follows reset release until a full new window completes.

Verification
REQ-029 Bench SHALL cover: NUM_SAMPLES=3, SYNC_STAGES=0, Prescale=8, rx_s=1 at edge_cnt 2,3,4 -> one cycle after edge_cnt=4: sampled_bit=1, sample_valid=1 for one cycle, noise_flag=0.
REQ-030 Bench SHALL cover: NUM_SAMPLES=3, Prescale=16, rx_s=0,1,0 at edge_cnt 6,7,8 -> sampled_bit=0, noise_flag=1.
REQ-031 Bench SHALL cover: NUM_SAMPLES=5, Prescale=16, rx_s=1,0,1,0,1 at edge_cnt 5..9 -> sampled_bit=1, noise_flag=1, vote one cycle after edge_cnt=9.
REQ-032 Bench SHALL cover: NUM_SAMPLES=5, Prescale=4 -> cfg_err=1; no sample_valid over 3 bit periods; Prescale=8 -> cfg_err=0, the next full window votes.
REQ-033 Bench SHALL cover: data_samp_en dropped at edge_cnt=4 (Prescale=8, N=3) -> no sample_valid; sampled_bit=0 next cycle.
REQ-034 Bench SHALL cover: SYNC_STAGES=2, RX_IN toggled 1->0 two cycles before window -> first sample sees 1; reset pulsed at edge_cnt=3 -> all outputs 0, no vote for that bit.
